// File: rtl/load_store_unit_pkg.sv
// Shared core package: LSU access sizes, LSU FSM states and the
// register-file write-port select value that routes load data.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_SIZE_BYTE = 2'd0,
    LSU_SIZE_HALF = 2'd1,
    LSU_SIZE_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Register-file write-port A select: value 2 picks the LSU load result.
  localparam logic [1:0] RF_WP_A_SEL_LSU = 2'd2;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU: store byte enables and lane
// replication, misalignment detection, and load extraction with extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        st_misaligned_o,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;
  logic        ld_sign;

  always_comb begin
    st_be_o         = 4'b0000;
    st_wdata_o      = st_wdata_i;
    st_misaligned_o = 1'b0;
    case (st_size_i)
      LSU_SIZE_BYTE: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      LSU_SIZE_HALF: begin
        st_be_o         = 4'b0011 << st_off_i;
        st_wdata_o      = {2{st_wdata_i[15:0]}};
        st_misaligned_o = st_off_i[0];
      end
      LSU_SIZE_WORD: begin
        st_be_o         = 4'b1111;
        st_misaligned_o = |st_off_i;
      end
      default: st_misaligned_o = 1'b1;
    endcase
  end

  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_sign    = 1'b0;
    ld_data_o  = ld_shifted;
    case (ld_size_i)
      LSU_SIZE_BYTE: begin
        ld_sign   = ~ld_unsigned_i & ld_shifted[7];
        ld_data_o = {{24{ld_sign}}, ld_shifted[7:0]};
      end
      LSU_SIZE_HALF: begin
        ld_sign   = ~ld_unsigned_i & ld_shifted[15];
        ld_data_o = {{16{ld_sign}}, ld_shifted[15:0]};
      end
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding req/gnt/rvalid data-bus master that
// stalls the core while an access is in flight.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [1:0]              size_i,
  input  logic                    unsigned_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    misaligned_o,
  output logic                    err_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  input  logic                    data_err_i
);

  lsu_state_e state_q, state_d;

  logic [ADDR_WIDTH-3:0]   word_addr_q, word_addr_d;
  logic [1:0]              off_q, off_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH/8-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    data_req_q, data_req_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    mis_q, mis_d;
  logic                    err_q, err_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        st_misaligned;
  logic [31:0] ld_data;

  lsu_align u_align (
    .st_off_i        (addr_i[1:0]),
    .st_size_i       (size_i),
    .st_wdata_i      (wdata_i),
    .st_be_o         (st_be),
    .st_wdata_o      (st_wdata),
    .st_misaligned_o (st_misaligned),
    .ld_off_i        (off_q),
    .ld_size_i       (size_q),
    .ld_unsigned_i   (uns_q),
    .ld_rdata_i      (data_rdata_i),
    .ld_data_o       (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    data_req_d  = data_req_q;
    // Completion outputs are only non-zero during the single done cycle.
    done_d      = 1'b0;
    rdata_d     = '0;
    mis_d       = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      LSU_IDLE: begin
        if (req_i) begin
          if (st_misaligned) begin
            state_d = LSU_DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d     = LSU_REQ;
            word_addr_d = addr_i[ADDR_WIDTH-1:2];
            off_d       = addr_i[1:0];
            size_d      = size_i;
            uns_d       = unsigned_i;
            we_d        = we_i;
            be_d        = st_be;
            wdata_d     = st_wdata;
            data_req_d  = 1'b1;
          end
        end
      end
      LSU_REQ: begin
        if (data_gnt_i) begin
          state_d    = LSU_WAIT;
          data_req_d = 1'b0;
        end
      end
      LSU_WAIT: begin
        if (data_rvalid_i) begin
          state_d = LSU_DONE;
          done_d  = 1'b1;
          err_d   = data_err_i;
          rdata_d = (we_q || data_err_i) ? '0 : ld_data;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= LSU_IDLE;
      word_addr_q <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      data_req_q  <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      data_req_q  <= data_req_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
      err_q       <= err_d;
    end
  end

  assign busy_o = (state_q == LSU_IDLE && req_i) || state_q == LSU_REQ || state_q == LSU_WAIT;

  assign data_req_o   = data_req_q;
  assign data_addr_o  = {word_addr_q, 2'b00};
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;
  assign done_o       = done_q;
  assign rdata_o      = rdata_q;
  assign misaligned_o = mis_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: aligned loads/stores, extension,
// grant stalls, misalignment, bus error and reset mid-transaction.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, misaligned_o, err_o;
  logic [31:0] rdata_o;
  logic        data_req_o, data_gnt_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;
  logic        data_rvalid_i, data_err_i;

  always #5 clk_i = ~clk_i;

  load_store_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .we_i          (we_i),
    .size_i        (size_i),
    .unsigned_i    (unsigned_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .rdata_o       (rdata_o),
    .misaligned_o  (misaligned_o),
    .err_o         (err_o),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_addr_o   (data_addr_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_wdata_o  (data_wdata_o),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .data_err_i    (data_err_i)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the most recent access() call.
  int          r_lat;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_err, r_mis, r_we, r_stable, r_req_seen, r_done_after, r_busy_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one access, grant after gnt_wait request cycles, respond the cycle after grant.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int gnt_wait,
                        input logic [31:0] rdata, input logic err);
    int   waited = 0;
    logic gnt_prev = 1'b0;
    logic snap = 1'b0;
    req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
    #1;
    r_stable = busy_o; r_lat = -1; r_req_seen = 1'b0; r_busy_done = 1'bx;
    r_rdata = 'x; r_err = 1'bx; r_mis = 1'bx;
    step();
    for (int c = 1; c <= 40; c++) begin
      if (done_o) begin
        r_lat = c; r_rdata = rdata_o; r_err = err_o; r_mis = misaligned_o; r_busy_done = busy_o;
        break;
      end
      if (!busy_o) r_stable = 1'b0;
      if (data_req_o) begin
        r_req_seen = 1'b1;
        if (!snap) begin
          snap = 1'b1;
          r_addr = data_addr_o; r_be = data_be_o; r_wdata = data_wdata_o; r_we = data_we_o;
        end else if ({data_addr_o, data_be_o, data_wdata_o, data_we_o} !=
                     {r_addr, r_be, r_wdata, r_we}) begin
          r_stable = 1'b0;
        end
      end
      data_rvalid_i = gnt_prev;
      data_rdata_i  = gnt_prev ? rdata : 32'h0;
      data_err_i    = gnt_prev & err;
      data_gnt_i    = data_req_o && (waited == gnt_wait);
      if (data_req_o) waited++;
      gnt_prev = data_gnt_i;
      step();
    end
    req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    step();
    r_done_after = done_o;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; unsigned_i = 1'b0;
    addr_i = '0; wdata_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    data_rdata_i = '0; data_err_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
    check_eq("reset_flags", {28'h0, done_o, data_req_o, misaligned_o, err_o}, 32'h0);
    check_eq("reset_busy", busy_o, 1'b0);
    check_eq("reset_rdata", rdata_o, 32'h0);
    check_eq("reset_addr", data_addr_o, 32'h0);
    check_eq("reset_be", data_be_o, 4'h0);

    // LW aligned, same-cycle grant
    access(1'b0, LSU_SIZE_WORD, 1'b0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    check_eq("lw_lat", r_lat, 3);
    check_eq("lw_be", r_be, 4'hF);
    check_eq("lw_addr", r_addr, 32'h100);
    check_eq("lw_we", r_we, 1'b0);
    check_eq("lw_rdata", r_rdata, 32'hDEAD_BEEF);
    check_eq("lw_flags", {r_err, r_mis}, 2'b00);
    check_eq("lw_busy_in_done", r_busy_done, 1'b0);
    check_eq("lw_single_done", r_done_after, 1'b0);

    // LB / LBU from the top lane
    access(1'b0, LSU_SIZE_BYTE, 1'b0, 32'h103, 32'h0, 0, 32'h80FF_0000, 1'b0);
    check_eq("lb_be", r_be, 4'b1000);
    check_eq("lb_addr", r_addr, 32'h100);
    check_eq("lb_rdata", r_rdata, 32'hFFFF_FF80);
    access(1'b0, LSU_SIZE_BYTE, 1'b1, 32'h103, 32'h0, 0, 32'h80FF_0000, 1'b0);
    check_eq("lbu_rdata", r_rdata, 32'h0000_0080);

    // LH / LHU from the upper half
    access(1'b0, LSU_SIZE_HALF, 1'b0, 32'h12, 32'h0, 0, 32'h8001_1234, 1'b0);
    check_eq("lh_be", r_be, 4'b1100);
    check_eq("lh_rdata", r_rdata, 32'hFFFF_8001);
    access(1'b0, LSU_SIZE_HALF, 1'b1, 32'h12, 32'h0, 0, 32'h8001_1234, 1'b0);
    check_eq("lhu_rdata", r_rdata, 32'h0000_8001);

    // SH with three grant wait-cycles
    access(1'b1, LSU_SIZE_HALF, 1'b0, 32'h202, 32'h1234_ABCD, 3, 32'h5A5A_5A5A, 1'b0);
    check_eq("sh_wdata", r_wdata, 32'hABCD_ABCD);
    check_eq("sh_be", r_be, 4'b1100);
    check_eq("sh_addr", r_addr, 32'h200);
    check_eq("sh_we", r_we, 1'b1);
    check_eq("sh_stable_busy", r_stable, 1'b1);
    check_eq("sh_lat", r_lat, 6);
    check_eq("sh_rdata_zero", r_rdata, 32'h0);
    check_eq("sh_single_done", r_done_after, 1'b0);

    // SB lane replication
    access(1'b1, LSU_SIZE_BYTE, 1'b0, 32'h301, 32'h0000_00A7, 0, 32'h0, 1'b0);
    check_eq("sb_wdata", r_wdata, 32'hA7A7_A7A7);
    check_eq("sb_be", r_be, 4'b0010);

    // Misaligned word and illegal size
    access(1'b0, LSU_SIZE_WORD, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1'b0);
    check_eq("mis_lw_lat", r_lat, 1);
    check_eq("mis_lw_flag", r_mis, 1'b1);
    check_eq("mis_lw_noreq", r_req_seen, 1'b0);
    check_eq("mis_lw_rdata", r_rdata, 32'h0);
    access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b0);
    check_eq("mis_sz3_lat", r_lat, 1);
    check_eq("mis_sz3_flag", r_mis, 1'b1);
    check_eq("mis_sz3_noreq", r_req_seen, 1'b0);
    access(1'b0, LSU_SIZE_HALF, 1'b0, 32'h103, 32'h0, 0, 32'h0, 1'b0);
    check_eq("mis_lh_flag", r_mis, 1'b1);

    // Bus error on LH
    access(1'b0, LSU_SIZE_HALF, 1'b0, 32'h10, 32'h0, 0, 32'h5555_AAAA, 1'b1);
    check_eq("err_flag", r_err, 1'b1);
    check_eq("err_rdata", r_rdata, 32'h0);
    check_eq("err_lat", r_lat, 3);
    check_eq("err_mis", r_mis, 1'b0);

    // Reset while waiting for the response
    req_i = 1'b1; we_i = 1'b0; size_i = LSU_SIZE_WORD; unsigned_i = 1'b0; addr_i = 32'h40;
    step();
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    check_eq("rst_wait_noreq", data_req_o, 1'b0);
    rst_ni = 1'b0;
    #1;
    check_eq("rst_abort_flags", {28'h0, done_o, data_req_o, misaligned_o, err_o}, 32'h0);
    check_eq("rst_abort_addr", data_addr_o, 32'h0);
    req_i = 1'b0;
    step();
    #2 rst_ni = 1'b1;
    step();
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_2222;
    step();
    data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    check_eq("rst_late_rvalid_done", done_o, 1'b0);
    check_eq("rst_late_rvalid_rdata", rdata_o, 32'h0);
    check_eq("rst_late_rvalid_busy", busy_o, 1'b0);
    step();
    check_eq("rst_late_rvalid_done2", done_o, 1'b0);
    access(1'b0, LSU_SIZE_WORD, 1'b0, 32'h40, 32'h0, 0, 32'h1357_9BDF, 1'b0);
    check_eq("post_rst_lat", r_lat, 3);
    check_eq("post_rst_rdata", r_rdata, 32'h1357_9BDF);
    check_eq("post_rst_addr", r_addr, 32'h40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit sitting downstream of the ALU operand/write-back glue. It takes the ALU result as the effective address and rs2 as store data, and runs a single-outstanding request/grant/response transaction on the data memory bus. It aligns store data to byte lanes, extracts and extends load data, and returns the load value to the register-file write-port mux through the new select `RF_WP_A_SEL_LSU`. While a transaction is in flight it stalls the core.

## Interface
- `DATA_WIDTH`, 32, data bus and register width; must be 32.
- `ADDR_WIDTH`, 32, address width.

- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in 1: load/store instruction present. Held by the core until `done_o`.
- `we_i` in 1: 1 = store, 0 = load.
- `size_i` in 2: `LSU_SIZE_BYTE`=0, `LSU_SIZE_HALF`=1, `LSU_SIZE_WORD`=2; 3 is illegal.
- `unsigned_i` in 1: zero-extend loads (LBU/LHU).
- `addr_i` in ADDR_WIDTH: effective address (ALU result).
- `wdata_i` in DATA_WIDTH: store data (rs2).
- `busy_o` out 1: stall request to the core.
- `done_o` out 1: one-cycle completion pulse.
- `rdata_o` out DATA_WIDTH: extended load result; valid while `done_o`=1.
- `misaligned_o` out 1: with `done_o`, the access was misaligned or illegal; no bus access was made.
- `err_o` out 1: with `done_o`, the bus returned an error.
- `data_req_o` out 1: bus request.
- `data_gnt_i` in 1: bus grant.
- `data_addr_o` out ADDR_WIDTH: word-aligned address `{addr[ADDR_WIDTH-1:2],2'b00}`.
- `data_we_o` out 1: bus write enable.
- `data_be_o` out DATA_WIDTH/8: byte enables.
- `data_wdata_o` out DATA_WIDTH: lane-replicated store data.
- `data_rvalid_i` in 1: response valid.
- `data_rdata_i` in DATA_WIDTH: response data.
- `data_err_i` in 1: response error; qualified by `data_rvalid_i`.

## Operation
- **FSM states** (`lsu_state_e`): `LSU_IDLE`, `LSU_REQ`, `LSU_WAIT`, `LSU_DONE`.
- **`LSU_IDLE`**
  - `req_i` with a legal, aligned access: register address, we, be, wdata, size and unsigned, then go to `LSU_REQ`.
  - `req_i` with a misaligned or illegal access: go to `LSU_DONE` with a misaligned flag.
- **`LSU_REQ`**: `data_req_o`=1 and all bus outputs held stable. `data_gnt_i`=1 goes to `LSU_WAIT`; otherwise stay.
- **`LSU_WAIT`**: `data_rvalid_i`=1 captures the result and goes to `LSU_DONE`. `data_rvalid_i` outside `LSU_WAIT` is ignored.
- **`LSU_DONE`**: `done_o`=1 for exactly one cycle, then `LSU_IDLE`. `req_i` in this cycle is ignored.
- **Misaligned**: half with `addr[0]`=1, word with `addr[1:0]`≠0, or `size_i`=3.
- **Byte enables**, with off=`addr[1:0]`: byte `4'b0001<<off`; half `4'b0011<<off`; word `4'b1111`.
- **Store data**: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word unchanged.
- **Load data**: `rdata_i >> (8*off)`, truncated to size, then sign-extended (or zero-extended if `unsigned_i`) to 32 bits.
- **Forced zero `rdata_o`**: stores, errors and misaligned completions give `rdata_o`=0.
- **`busy_o`**: `(state==LSU_IDLE & req_i) | state==LSU_REQ | state==LSU_WAIT`, combinational. Low in `LSU_DONE`, so the core advances at the end of the done cycle.

## Timing
- **Reset values**: all registered outputs 0, state `LSU_IDLE`. Reset in any state aborts immediately; a late `data_rvalid_i` after reset is ignored.
- **Registered outputs**: `data_req_o`, `data_addr_o`, `data_we_o`, `data_be_o`, `data_wdata_o`, `done_o`, `rdata_o`, `misaligned_o`, `err_o`.
- **Aligned latency**, `req_i` sampled at edge 0:
  - `data_req_o` high in cycle 1.
  - With same-cycle grant and next-cycle rvalid, `done_o` is high in cycle 3.
  - Each grant wait-cycle or rvalid wait-cycle adds 1 cycle.
- **Misaligned latency**: `done_o` in cycle 1 with `misaligned_o`=1; `data_req_o` stays 0.
- **Outstanding requests**: one at most; `data_req_o` is 0 in `LSU_WAIT` and `LSU_DONE`.
- **`err_o`**: set when `data_rvalid_i & data_err_i`; `rdata_o`=0.

## Structure
- **Shared core package** (alongside the ALU/RF select constants):
  - `lsu_size_e` and `lsu_state_e`.
  - `RF_WP_A_SEL_LSU` = 2, a new value for the existing 2-bit RF write-port select.
- **Sub-module `lsu_align`** (combinational): be/wdata generation, misalignment detection, load extraction and extension. The FSM stays in `load_store_unit`.

## Test plan
- **LW, aligned**: LW addr `0x100`, gnt same cycle, rvalid next with `0xDEADBEEF` → `data_be_o`=`4'hF`, `data_addr_o`=`0x100`, `done_o` in cycle 3, `rdata_o`=`0xDEADBEEF`.
- **LB/LBU**: LB addr `0x103`, `rdata_i`=`0x80FF_0000` → `be`=`4'b1000`, `rdata_o`=`0xFFFF_FF80`; LBU same → `0x0000_0080`.
- **SH with grant stall**: SH addr `0x202`, `wdata`=`0x1234_ABCD`, gnt delayed 3 cycles → `data_wdata_o`=`0xABCD_ABCD`, `be`=`4'b1100`, bus outputs stable and `busy_o`=1 throughout, single `done_o`.
- **Misaligned**: LW addr `0x101` → `done_o`+`misaligned_o` in cycle 1, `data_req_o` never 1; `size_i`=3 gives the same result.
- **Bus error**: LH addr `0x10` with rvalid+err → `err_o`=1, `rdata_o`=0.
- **Reset mid-transaction**: `rst_ni` low during `LSU_WAIT`, then rvalid after release → outputs 0, no `done_o`, next LW completes normally.
